data_mem_hs: RTL and testbench

DATA_MEM_HS -- requirements
Module: data_mem_hs

---
 rtl/data_mem_hs_if.sv | 24 ++
 rtl/data_mem_hs.sv | 139 +++++++++++++
 tb/tb_data_mem_hs.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_hs_if.sv
// rtl/data_mem_hs_if.sv - request/response bus bundle for data_mem_hs
interface data_mem_hs_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12
);
    logic              req_valid;
    logic              req_ready;
    logic              req_wr;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              busy;

    modport master (
        output req_valid, req_wr, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, busy
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, busy
    );
endinterface

// File: rtl/data_mem_hs.sv
// rtl/data_mem_hs.sv - handshaked single-port data memory with wait states; optional DMEM_INIT_CLEAR_EN clears the array after reset
module data_mem_hs #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 12,
    parameter int WAIT_STATES = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    data_mem_hs_if.slave  bus
);
    localparam int         DEPTH     = 2 ** ADDR_W;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

`ifdef DMEM_INIT_CLEAR_EN
    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_WAIT, ST_RESP} state_t;
    localparam state_t RST_STATE = ST_INIT;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;
    localparam state_t RST_STATE = ST_IDLE;
`endif

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              accept;
    logic              commit;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_q [DEPTH];

`ifdef DMEM_INIT_CLEAR_EN
    logic [ADDR_W-1:0] init_addr_q, init_addr_d;
    logic              init_we;
`endif

    // Next-state logic: accept in IDLE, count down in WAIT, one-cycle RESP
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        commit  = 1'b0;
`ifdef DMEM_INIT_CLEAR_EN
        init_addr_d = init_addr_q;
        init_we     = 1'b0;
`endif
        case (state_q)
`ifdef DMEM_INIT_CLEAR_EN
            ST_INIT: begin
                init_we     = 1'b1;
                init_addr_d = init_addr_q + 1'b1;
                if (init_addr_q == {ADDR_W{1'b1}}) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            ST_IDLE: begin
                if (bus.req_valid) begin
                    accept  = 1'b1;
                    state_d = ST_WAIT;
                    cnt_d   = WAIT_LOAD;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    commit  = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = RST_STATE;
        endcase
    end

    // Single RAM port: clear sweep during INIT, otherwise the latched request
    always_comb begin
        mem_we    = commit && wr_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
`ifdef DMEM_INIT_CLEAR_EN
        if (init_we) begin
            mem_we    = 1'b1;
            mem_addr  = init_addr_q;
            mem_wdata = '0;
        end
`endif
    end

    // Control registers and request capture on acceptance
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RST_STATE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef DMEM_INIT_CLEAR_EN
            init_addr_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                wr_q    <= bus.req_wr;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
            end
`ifdef DMEM_INIT_CLEAR_EN
            init_addr_q <= init_addr_d;
`endif
        end
    end

    // Array write; reset blocks a write that would commit on the reset edge
    always_ff @(posedge clk) begin
        if (rst_n && mem_we) begin
            mem_q[mem_addr] <= mem_wdata;
        end
    end

    // Read data register: loaded only when a read completes, else held
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (commit && !wr_q) begin
            rdata_q <= mem_q[addr_q];
        end
    end

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.busy      = (state_q != ST_IDLE);
endmodule

// File: tb/tb_data_mem_hs.sv
// tb/tb_data_mem_hs.sv - randomized self-checking bench for data_mem_hs
module tb_data_mem_hs;
    localparam int DW    = 16;
    localparam int AW    = 12;
    localparam int WS    = 1;
    localparam int DEPTH = 2 ** AW;
    localparam logic [AW-1:0] AMAX = {AW{1'b1}};

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    data_mem_hs_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    data_mem_hs #(.DATA_W(DW), .ADDR_W(AW), .WAIT_STATES(WS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] model_mem [int];
    logic [DW-1:0] last_rd;
    logic [AW-1:0] known_addr [$];

    function automatic void model_reset();
        last_rd = '0;
        model_mem.delete();
        known_addr.delete();
`ifdef DMEM_INIT_CLEAR_EN
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
`endif
    endfunction

    function automatic void model_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        model_mem[int'(a)] = d;
        known_addr.push_back(a);
    endfunction

    // Presents one request, waits for acceptance, measures cycles to rsp_valid
    task automatic drive_txn(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                             output int lat, output logic [DW-1:0] rd, output logic held_off);
        int t;
        bus.req_valid = 1'b1;
        bus.req_wr    = wr;
        bus.req_addr  = a;
        bus.req_wdata = d;
        t = 0;
        while (!bus.req_ready && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_wr    = 1'($urandom);
        bus.req_addr  = AW'($urandom);
        bus.req_wdata = DW'($urandom);
        lat = 0;
        held_off = 1'b1;
        while (!bus.rsp_valid && lat < 64) begin
            if (bus.req_ready || !bus.busy) held_off = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if (t >= 100) lat = -1;
        rd = bus.rsp_rdata;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        int n;
        rst_n = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_wr = 1'b0;
        bus.req_addr = '0;
        bus.req_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid got=%b exp=0", bus.rsp_valid); end
        n_cmp++; if (bus.rsp_rdata !== '0) begin n_err++; $display("FAIL reset_rsp_rdata got=%h exp=0000", bus.rsp_rdata); end
`ifdef DMEM_INIT_CLEAR_EN
        n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL reset_busy got=%b exp=1", bus.busy); end
        rst_n = 1'b1;
        n = 0;
        while (bus.busy === 1'b1 && n < DEPTH + 10) begin
            if (bus.req_ready !== 1'b0) begin n_cmp++; n_err++; $display("FAIL init_ready got=%b exp=0", bus.req_ready); end
            @(posedge clk); #1;
            n++;
        end
        n_cmp++; if (n != DEPTH) begin n_err++; $display("FAIL init_busy_cycles got=%0d exp=%0d", n, DEPTH); end
`else
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        rst_n = 1'b1;
        n = 0;
        n_cmp++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL first_cycle_ready got=%b exp=1", bus.req_ready); end
`endif
        model_reset();
    endtask

    task automatic test_directed();
        int lat;
        logic [DW-1:0] rd;
        logic ho;
        drive_txn(1'b1, 12'h005, 16'hBEEF, lat, rd, ho);
        model_write(12'h005, 16'hBEEF);
        n_cmp++; if (lat != WS + 1) begin n_err++; $display("FAIL wr_latency got=%0d exp=%0d", lat, WS + 1); end
        n_cmp++; if (ho !== 1'b1) begin n_err++; $display("FAIL wr_ready_held_low got=%b exp=1", ho); end
        n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL rsp_one_cycle got=%b exp=0", bus.rsp_valid); end
        n_cmp++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL ready_after_resp got=%b exp=1", bus.req_ready); end
        drive_txn(1'b0, 12'h005, 16'h0000, lat, rd, ho);
        n_cmp++; if (rd !== 16'hBEEF) begin n_err++; $display("FAIL rd_after_wr got=%h exp=beef", rd); end
        n_cmp++; if (lat != WS + 1) begin n_err++; $display("FAIL rd_latency got=%0d exp=%0d", lat, WS + 1); end
        last_rd = 16'hBEEF;
        drive_txn(1'b1, 12'h006, 16'h1234, lat, rd, ho);
        model_write(12'h006, 16'h1234);
        n_cmp++; if (rd !== last_rd) begin n_err++; $display("FAIL rdata_hold_on_wr got=%h exp=%h", rd, last_rd); end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (bus.rsp_rdata !== last_rd) begin n_err++; $display("FAIL rdata_hold_idle got=%h exp=%h", bus.rsp_rdata, last_rd); end
    endtask

    task automatic test_random();
        int lat;
        logic [DW-1:0] rd, exp_rd, d;
        logic [AW-1:0] a;
        logic ho, wr;
        for (int i = 0; i < 24; i++) begin
            wr = (known_addr.size() == 0) || ($urandom_range(0, 1) == 0);
            if (wr) begin
                case ($urandom_range(0, 3))
                    0: a = '0;
                    1: a = AMAX;
                    default: a = AW'($urandom);
                endcase
                d = DW'($urandom);
                exp_rd = last_rd;
                drive_txn(1'b1, a, d, lat, rd, ho);
                model_write(a, d);
            end else begin
                a = known_addr[$urandom_range(0, known_addr.size() - 1)];
                exp_rd = model_mem[int'(a)];
                drive_txn(1'b0, a, DW'($urandom), lat, rd, ho);
                last_rd = exp_rd;
            end
            n_cmp++; if (rd !== exp_rd) begin n_err++; $display("FAIL rand_rdata i=%0d wr=%b addr=%h got=%h exp=%h", i, wr, a, rd, exp_rd); end
            n_cmp++; if (lat != WS + 1) begin n_err++; $display("FAIL rand_latency i=%0d got=%0d exp=%0d", i, lat, WS + 1); end
            n_cmp++; if (ho !== 1'b1) begin n_err++; $display("FAIL rand_ready_held_low i=%0d got=%b exp=1", i, ho); end
        end
    endtask

    task automatic test_back_to_back();
        int last_acc, n_acc, lat, t;
        logic acc, ho;
        logic [AW-1:0] a, acc_addr [$];
        logic [DW-1:0] d, rd, exp_rd;
        last_acc = -1;
        n_acc = 0;
        bus.req_valid = 1'b1;
        for (int c = 0; c < 5 * (WS + 3); c++) begin
            a = AW'($urandom);
            d = DW'($urandom);
            bus.req_wr = 1'b1;
            bus.req_addr = a;
            bus.req_wdata = d;
            acc = bus.req_ready;
            @(posedge clk); #1;
            if (acc) begin
                if (last_acc < 0) begin
                    n_cmp++; if (c != 0) begin n_err++; $display("FAIL b2b_first_accept got=%0d exp=0", c); end
                end else begin
                    n_cmp++; if (c - last_acc != WS + 3) begin n_err++; $display("FAIL b2b_spacing got=%0d exp=%0d", c - last_acc, WS + 3); end
                end
                model_write(a, d);
                acc_addr.push_back(a);
                last_acc = c;
                n_acc++;
            end
            n_cmp++;
            if (bus.rsp_valid !== (last_acc >= 0 && c == last_acc + WS + 1)) begin
                n_err++; $display("FAIL b2b_rsp_valid c=%0d got=%b", c, bus.rsp_valid);
            end
        end
        bus.req_valid = 1'b0;
        n_cmp++; if (n_acc != 5) begin n_err++; $display("FAIL b2b_accept_count got=%0d exp=5", n_acc); end
        t = 0;
        while (bus.busy && t < 50) begin @(posedge clk); #1; t++; end
        n_cmp++; if (t >= 50) begin n_err++; $display("FAIL b2b_idle_timeout got=%0d exp<50", t); end
        foreach (acc_addr[k]) begin
            exp_rd = model_mem[int'(acc_addr[k])];
            drive_txn(1'b0, acc_addr[k], '0, lat, rd, ho);
            last_rd = exp_rd;
            n_cmp++; if (rd !== exp_rd) begin n_err++; $display("FAIL b2b_readback addr=%h got=%h exp=%h", acc_addr[k], rd, exp_rd); end
        end
    endtask

    task automatic test_reset_abort();
        int lat, n;
        logic [DW-1:0] rd, exp_rd;
        logic ho, seen;
        drive_txn(1'b1, AMAX, 16'hAAAA, lat, rd, ho);
        model_write(AMAX, 16'hAAAA);
        bus.req_valid = 1'b1;
        bus.req_wr = 1'b1;
        bus.req_addr = AMAX;
        bus.req_wdata = 16'h5555;
        n = 0;
        while (!bus.req_ready && n < 100) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        rst_n = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < WS + 3; c++) begin
            @(posedge clk); #1;
            if (bus.rsp_valid) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL abort_rsp_valid got=%b exp=0", seen); end
        n_cmp++; if (bus.rsp_rdata !== '0) begin n_err++; $display("FAIL abort_rdata_cleared got=%h exp=0000", bus.rsp_rdata); end
        rst_n = 1'b1;
        last_rd = '0;
`ifdef DMEM_INIT_CLEAR_EN
        model_reset();
        n = 0;
        while (bus.busy && n < DEPTH + 10) begin @(posedge clk); #1; n++; end
`endif
        n_cmp++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL abort_ready got=%b exp=1", bus.req_ready); end
        exp_rd = model_mem[int'(AMAX)];
        drive_txn(1'b0, AMAX, '0, lat, rd, ho);
        last_rd = exp_rd;
        n_cmp++; if (rd !== exp_rd) begin n_err++; $display("FAIL abort_no_commit got=%h exp=%h", rd, exp_rd); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
